// File: rtl/ram_dump.sv
// ram_dump: reads one channel's circular capture buffer, oldest entry
// first, and hands each byte to the UART through send_resp/resp_sent.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dump_req, dump_ch   start pulse and channel select (1..5)
//   waddr               capture write pointer; the oldest sample lives here
//   rdataCH1..5         registered-read RAM data, valid one cycle after raddr
//   resp_sent           UART pulse: the current byte has left the transmitter
//   raddr               read address broadcast to all five RAMs
//   resp, send_resp     byte to transmit and its one-cycle start pulse
//   dump_busy           high while a dump is in progress
//   dump_done           one-cycle pulse after the last byte is sent
//   dump_err            one-cycle pulse for a request with a bad channel
module ram_dump #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_req,
    input  logic [2:0]    dump_ch,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    rdataCH1,
    input  logic [7:0]    rdataCH2,
    input  logic [7:0]    rdataCH3,
    input  logic [7:0]    rdataCH4,
    input  logic [7:0]    rdataCH5,
    input  logic          resp_sent,
    output logic [AW-1:0] raddr,
    output logic [7:0]    resp,
    output logic          send_resp,
    output logic          dump_busy,
    output logic          dump_done,
    output logic          dump_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_SND,
        S_WT
    } state_t;

    // One extra bit so ENTRIES == 2**AW still compares correctly.
    localparam logic [AW:0]   ENT  = (AW+1)'(ENTRIES);
    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    state_t        state_q, state_d;
    logic [2:0]    ch_q, ch_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    resp_q, resp_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          ch_ok;
    logic          req_ok;
    logic [7:0]    rdata_sel;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= 3'd0;
            raddr_q <= '0;
            cnt_q   <= '0;
            resp_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (ch_q)
            3'd1:    rdata_sel = rdataCH1;
            3'd2:    rdata_sel = rdataCH2;
            3'd3:    rdata_sel = rdataCH3;
            3'd4:    rdata_sel = rdataCH4;
            3'd5:    rdata_sel = rdataCH5;
            default: rdata_sel = 8'h00;
        endcase
    end

    // A request landing in the dump_done cycle is still ignored, even
    // though the FSM is already back in IDLE.
    always_comb begin
        ch_ok  = (dump_ch >= 3'd1) && (dump_ch <= 3'd5);
        req_ok = dump_req && (state_q == S_IDLE) && !done_q;
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok && ch_ok) begin
                    state_d = S_RD;
                    ch_d    = dump_ch;
                    raddr_d = ({1'b0, waddr} >= ENT) ? '0 : waddr;
                    cnt_d   = '0;
                end else if (req_ok) begin
                    err_d = 1'b1;
                end
            end
            S_RD: state_d = S_LD;
            S_LD: begin
                resp_d  = rdata_sel;
                state_d = S_SND;
            end
            S_SND: state_d = S_WT;
            S_WT: begin
                if (resp_sent) begin
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        raddr_d = (raddr_q == LAST) ? '0 : raddr_q + 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        raddr     = raddr_q;
        resp      = resp_q;
        send_resp = (state_q == S_SND);
        dump_busy = (state_q != S_IDLE);
        dump_done = done_q;
        dump_err  = err_q;
    end

endmodule

// File: tb/tb_ram_dump.sv
// Testbench for ram_dump: RAM and UART models, randomized data and
// handshake delays, scoreboard of expected bytes checked by a monitor.
module tb_ram_dump;

    localparam int ENTRIES = 384;
    localparam int AW      = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dump_req = 1'b0;
    logic [2:0]    dump_ch = 3'd0;
    logic [AW-1:0] waddr = '0;
    logic          resp_sent = 1'b0;
    logic [7:0]    rdata [5];
    logic [AW-1:0] raddr;
    logic [7:0]    resp;
    logic          send_resp, dump_busy, dump_done, dump_err;

    logic [7:0]    mem [5][ENTRIES];

    typedef struct {
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   byte_idx = 0;
    int   slow_idx = -1;
    int   slow_len = 0;
    int   checks = 0;
    int   failures = 0;

    ram_dump #(.ENTRIES(ENTRIES), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .dump_req(dump_req), .dump_ch(dump_ch), .waddr(waddr),
        .rdataCH1(rdata[0]), .rdataCH2(rdata[1]), .rdataCH3(rdata[2]),
        .rdataCH4(rdata[3]), .rdataCH5(rdata[4]),
        .resp_sent(resp_sent),
        .raddr(raddr), .resp(resp), .send_resp(send_resp),
        .dump_busy(dump_busy), .dump_done(dump_done), .dump_err(dump_err)
    );

    always #5 clk = ~clk;

    // Registered-read RAMs.
    always @(posedge clk) begin
        for (int c = 0; c < 5; c++)
            rdata[c] <= (int'(raddr) < ENTRIES) ? mem[c][raddr] : 8'h00;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every send_resp.
    always @(negedge clk) begin
        if (!rst) begin
            if (send_resp) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_send", 1, 0);
                end else begin
                    chk("resp", int'(resp), int'(exp_q[0].data));
                    chk("raddr", int'(raddr), int'(exp_q[0].addr));
                    chk("busy_during_send", int'(dump_busy), 1);
                    void'(exp_q.pop_front());
                end
            end
            if (dump_done) begin
                chk("done_bytes_left", exp_q.size(), 0);
                chk("done_expected", int'(exp_done > 0), 1);
                chk("busy_at_done", int'(dump_busy), 0);
                if (exp_done > 0) exp_done--;
                done_cnt++;
            end
            if (dump_err) err_cnt++;
            chk("raddr_range", int'(int'(raddr) < ENTRIES), 1);
        end
    end

    // UART model: answers each send_resp after a random delay and checks
    // that resp/raddr stay put while the slow byte is outstanding.
    initial begin
        forever begin
            @(negedge clk);
            if (send_resp && !rst) begin
                int          d;
                int          me;
                logic [7:0]  hr;
                logic [AW-1:0] ha;
                bit          abort;
                me    = byte_idx;
                d     = (me == slow_idx) ? slow_len : int'($urandom_range(1, 4));
                hr    = resp;
                ha    = raddr;
                abort = 1'b0;
                byte_idx++;
                for (int i = 0; i < d; i++) begin
                    @(posedge clk);
                    #1;
                    if (rst) abort = 1'b1;
                    else if (!abort && me == slow_idx) begin
                        chk("hold_resp", int'(resp), int'(hr));
                        chk("hold_raddr", int'(raddr), int'(ha));
                        chk("hold_no_send", int'(send_resp), 0);
                    end
                end
                if (!abort) begin
                    resp_sent = 1'b1;
                    @(posedge clk);
                    #1;
                    resp_sent = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int ch, input int wa);
        if (ch >= 1 && ch <= 5) begin
            int st;
            st = (wa >= ENTRIES) ? 0 : wa;
            for (int j = 0; j < ENTRIES; j++) begin
                exp_t e;
                e.addr = AW'((st + j) % ENTRIES);
                e.data = mem[ch-1][(st + j) % ENTRIES];
                exp_q.push_back(e);
            end
            exp_done++;
            byte_idx = 0;
        end
        dump_req = 1'b1;
        dump_ch  = 3'(ch);
        waddr    = AW'(wa);
        tick();
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int s;
        int n;
        s = done_cnt;
        n = 0;
        while (done_cnt == s && n < 20000) begin
            tick();
            n++;
        end
        chk(name, int'(done_cnt > s), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_resp"}, int'(resp), 0);
        chk({tag, "_send"}, int'(send_resp), 0);
        chk({tag, "_busy"}, int'(dump_busy), 0);
        chk({tag, "_done"}, int'(dump_done), 0);
        chk({tag, "_err"}, int'(dump_err), 0);
    endtask

    task automatic bad_req(input int ch);
        int e0;
        int r0;
        e0 = err_cnt;
        r0 = int'(raddr);
        issue(ch, 7);
        tick(2);
        chk("err_pulse", err_cnt, e0 + 1);
        chk("err_busy", int'(dump_busy), 0);
        chk("err_raddr", int'(raddr), r0);
    endtask

    initial begin
        int n;
        for (int c = 0; c < 5; c++)
            for (int i = 0; i < ENTRIES; i++)
                mem[c][i] = (c == 0 || c == 2) ? 8'(i % 256) : 8'($urandom);

        tick(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick(2);
        chk_outputs_zero("idle");

        // Straight dump from address 0.
        issue(3, 0);
        tick();
        chk("busy_after_req", int'(dump_busy), 1);
        wait_done("done_ch3");

        // Invalid channels.
        bad_req(0);
        bad_req(6);
        bad_req(7);

        // Wrapping start, slow byte 5, stray request while busy.
        slow_idx = 5;
        slow_len = 50;
        issue(1, 380);
        n = 0;
        while (byte_idx < 10 && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_byte10", int'(byte_idx >= 10), 1);
        dump_req = 1'b1;
        dump_ch  = 3'd2;
        waddr    = AW'(0);
        tick();
        dump_req = 1'b0;
        wait_done("done_ch1");
        slow_idx = -1;

        // Reset during WT of byte 100.
        slow_idx = 100;
        slow_len = 30;
        issue(4, int'($urandom_range(0, 511)));
        n = 0;
        while (byte_idx < 101 && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_byte100", int'(byte_idx >= 101), 1);
        tick(3);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        exp_done = 0;
        tick(2);
        rst = 1'b0;
        tick(60);
        chk("post_reset_busy", int'(dump_busy), 0);
        slow_idx = -1;

        // Back-to-back dumps, random start pointers.
        issue(2, int'($urandom_range(0, 511)));
        wait_done("done_ch2");
        issue(5, int'($urandom_range(0, 511)));
        tick();
        chk("b2b_busy", int'(dump_busy), 1);
        wait_done("done_ch5");
        tick(5);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
